// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential double-dabble BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int DIGIT_W    = 4;
    localparam int ADJ_THRESH = 5;
    localparam int ADJ_ADD    = 3;

    // Width needed to hold values 0..n-1; never less than one bit.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >>> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift the chain
// left by one bit, bringing bit_in in at the bottom.
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
    input  logic                      bit_in,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                      carry_out
);

    logic [DIGIT_W*DIGITS-1:0] adj;

    // NOTE: every output of a combinational block is assigned a default first so no latch is inferred.
    always_comb begin
        adj = bcd_in;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[i*DIGIT_W +: DIGIT_W] >= DIGIT_W'(ADJ_THRESH)) begin
                adj[i*DIGIT_W +: DIGIT_W] = bcd_in[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(ADJ_ADD);
            end
        end
        {carry_out, bcd_out} = {adj, bit_in};
    end

endmodule

// File: rtl/bcd_seq_conv.sv
// Multi-cycle binary-to-BCD converter: one input bit per clock, optional
// two's-complement input, start/busy/done handshake and overflow flag.
module bcd_seq_conv
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WIDTH-1:0]          numero,
    input  logic                      signed_en,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] digits,
    output logic                      neg,
    output logic                      overflow
);

    localparam int CNT_W = clog2(WIDTH);
    localparam int BCD_W = DIGIT_W * DIGITS;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mag;
    logic [BCD_W-1:0]   bcd;
    logic               ovf_w;
    logic               neg_w;

    logic               accept;
    logic               last_step;
    logic               op_neg;
    logic [BCD_W-1:0]   step_bcd;
    logic               step_carry;

    assign accept    = start && (state == IDLE || state == DONE);
    assign last_step = (state == SHIFT) && (cnt == '0);
    assign op_neg    = signed_en & numero[WIDTH-1];

    bcd_dabble_step #(
        .DIGITS(DIGITS)
    ) u_step (
        .bcd_in   (bcd),
        .bit_in   (mag[WIDTH-1]),
        .bcd_out  (step_bcd),
        .carry_out(step_carry)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == '0) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Working registers; the magnitude of a negative operand is formed once at accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            mag   <= '0;
            bcd   <= '0;
            ovf_w <= 1'b0;
            neg_w <= 1'b0;
        end else if (accept) begin
            cnt   <= CNT_W'(WIDTH - 1);
            mag   <= op_neg ? (~numero + WIDTH'(1)) : numero;
            bcd   <= '0;
            ovf_w <= 1'b0;
            neg_w <= op_neg;
        end else if (state == SHIFT) begin
            cnt   <= cnt - CNT_W'(1);
            mag   <= mag << 1;
            bcd   <= step_bcd;
            ovf_w <= ovf_w | step_carry;
        end
    end

    // Visible results change only on the edge that enters DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            digits   <= '0;
            neg      <= 1'b0;
            overflow <= 1'b0;
        end else if (last_step) begin
            digits   <= step_bcd;
            neg      <= neg_w;
            overflow <= ovf_w | step_carry;
        end
    end

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Directed bench for bcd_seq_conv: default 32-bit/4-digit instance plus an
// 8-bit/3-digit instance sharing clock and reset.
module tb_bcd_seq_conv;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        start = 1'b0;
    logic [31:0] numero = '0;
    logic        signed_en = 1'b0;
    logic        busy, done, neg, overflow;
    logic [15:0] digits;

    logic        s_start = 1'b0;
    logic [7:0]  s_numero = '0;
    logic        s_signed_en = 1'b0;
    logic        s_busy, s_done, s_neg, s_overflow;
    logic [11:0] s_digits;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    bcd_seq_conv #(.WIDTH(32), .DIGITS(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .numero   (numero),
        .signed_en(signed_en),
        .busy     (busy),
        .done     (done),
        .digits   (digits),
        .neg      (neg),
        .overflow (overflow)
    );

    bcd_seq_conv #(.WIDTH(8), .DIGITS(3)) dut_small (
        .clock    (clock),
        .reset    (reset),
        .start    (s_start),
        .numero   (s_numero),
        .signed_en(s_signed_en),
        .busy     (s_busy),
        .done     (s_done),
        .digits   (s_digits),
        .neg      (s_neg),
        .overflow (s_overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_conv(input logic [31:0] v, input logic s);
        @(negedge clock);
        start = 1'b1;
        numero = v;
        signed_en = s;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Waits for done, counting edges since the accept edge and busy samples.
    task automatic wait_done(inout int lat, output int busy_cyc);
        busy_cyc = 0;
        while (!done && lat < 200) begin
            if (busy) busy_cyc++;
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] v, input logic s,
                       input logic [15:0] exp_d, input logic exp_n, input logic exp_o);
        int lat;
        int bc;
        start_conv(v, s);
        lat = 0;
        wait_done(lat, bc);
        check({tag, " latency"}, 32'(lat), 32'd32);
        check({tag, " digits"}, 32'(digits), 32'(exp_d));
        check({tag, " neg"}, 32'(neg), 32'(exp_n));
        check({tag, " overflow"}, 32'(overflow), 32'(exp_o));
    endtask

    task automatic run_small(input string tag, input logic [7:0] v, input logic s,
                             input logic [11:0] exp_d, input logic exp_n);
        int lat;
        @(negedge clock);
        s_start = 1'b1;
        s_numero = v;
        s_signed_en = s;
        @(posedge clock);
        #1;
        s_start = 1'b0;
        lat = 0;
        while (!s_done && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd8);
        check({tag, " digits"}, 32'(s_digits), 32'(exp_d));
        check({tag, " neg"}, 32'(s_neg), 32'(exp_n));
        check({tag, " overflow"}, 32'(s_overflow), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int bc;
        int t1;
        int t2;
        int done_seen;

        repeat (3) @(posedge clock);
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst digits", 32'(digits), 32'd0);
        check("rst neg", 32'(neg), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Basic unsigned conversion with handshake timing.
        start_conv(32'd1234, 1'b0);
        lat = 0;
        wait_done(lat, bc);
        check("u1234 latency", 32'(lat), 32'd32);
        check("u1234 busy cycles", 32'(bc), 32'd32);
        check("u1234 digits", 32'(digits), 32'h1234);
        check("u1234 neg", 32'(neg), 32'd0);
        check("u1234 overflow", 32'(overflow), 32'd0);
        @(posedge clock);
        #1;
        check("u1234 done pulse", 32'(done), 32'd0);

        run("s-42", 32'hFFFF_FFD6, 1'b1, 16'h0042, 1'b1, 1'b0);
        run("u-42word", 32'hFFFF_FFD6, 1'b0, 16'h7254, 1'b0, 1'b1);
        run("u10000", 32'd10000, 1'b0, 16'h0000, 1'b0, 1'b1);
        run("u9999", 32'd9999, 1'b0, 16'h9999, 1'b0, 1'b0);

        // A second start during SHIFT and input changes mid-conversion have no effect.
        start_conv(32'd1111, 1'b0);
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        start = 1'b1;
        numero = 32'd2222;
        @(posedge clock);
        #1;
        start = 1'b0;
        numero = 32'hFFFF_FF00;
        signed_en = 1'b1;
        lat = 5;
        wait_done(lat, bc);
        check("ignore latency", 32'(lat), 32'd32);
        check("ignore digits", 32'(digits), 32'h1111);
        check("ignore neg", 32'(neg), 32'd0);
        done_seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done) done_seen++;
        end
        check("ignore not queued", 32'(done_seen), 32'd0);

        // Start held high: back-to-back conversions every WIDTH+1 cycles.
        @(negedge clock);
        start = 1'b1;
        numero = 32'd5;
        signed_en = 1'b0;
        @(posedge clock);
        #1;
        numero = 32'd7;
        lat = 0;
        wait_done(lat, bc);
        t1 = cyc;
        check("b2b first digits", 32'(digits), 32'h0005);
        @(posedge clock);
        #1;
        lat = 0;
        wait_done(lat, bc);
        t2 = cyc;
        @(negedge clock);
        start = 1'b0;
        check("b2b spacing", 32'(t2 - t1), 32'd33);
        check("b2b second digits", 32'(digits), 32'h0007);
        @(posedge clock);
        #1;

        run("s-123456", 32'hFFFE_1DC0, 1'b1, 16'h3456, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a conversion.
        start_conv(32'd4321, 1'b0);
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        #2;
        reset = 1'b1;
        #1;
        check("arst busy", 32'(busy), 32'd0);
        check("arst done", 32'(done), 32'd0);
        check("arst digits", 32'(digits), 32'd0);
        check("arst neg", 32'(neg), 32'd0);
        check("arst overflow", 32'(overflow), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done) done_seen++;
        end
        check("arst no done", 32'(done_seen), 32'd0);
        run("post-rst u5678", 32'd5678, 1'b0, 16'h5678, 1'b0, 1'b0);

        // Narrow instance corners.
        run_small("w8 s-128", 8'h80, 1'b1, 12'h128, 1'b1);
        run_small("w8 s-100", 8'h9C, 1'b1, 12'h100, 1'b1);
        run_small("w8 u255", 8'hFF, 1'b0, 12'h255, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_seq_conv.md
Name: bcd_seq_conv

Overview:
- Multi-cycle, parametrised binary-to-BCD converter using the double-dabble algorithm, processing one input bit per clock.
- Generalises the fixed 32-bit / 4-digit combinational converter: WIDTH and DIGITS are parameters.
- Adds a runtime signed/unsigned mode, a start/busy/done handshake and an overflow flag.
- Feeds the display/debug path from the datapath result bus; trades latency for area versus the fully unrolled combinational form.

Parameters:
- WIDTH, 32, input word width in bits (>=2).
- DIGITS, 4, number of BCD output digits (>=1).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion; sampled only when the converter can accept.
- numero  input  WIDTH  value to convert; sampled with start.
- signed_en  input  1  1 = numero is two's complement; 0 = unsigned. Sampled with start.
- busy  output  1  high while a conversion is in progress (state SHIFT).
- done  output  1  one-cycle pulse: results updated this cycle.
- digits  output  4*DIGITS  BCD result; digit 0 is in bits [3:0], least significant digit.
- neg  output  1  sign of the last accepted operand.
- overflow  output  1  last result needed more than DIGITS digits.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - busy=0, done=0, digits=0, neg=0, overflow=0.
  - All working registers cleared.
  - An in-flight conversion is discarded; no done is produced for it.
- States:
  - IDLE to SHIFT on start.
  - SHIFT to DONE when the bit counter reaches 0.
  - DONE to SHIFT on start, otherwise DONE to IDLE.
- Accept:
  - start is accepted in IDLE or DONE; start during SHIFT is ignored (not queued).
  - On accept, capture:
    - neg_w = signed_en & numero[WIDTH-1].
    - mag = neg_w ? (~numero + 1) : numero, in WIDTH bits unsigned. For the most negative value, -2^(WIDTH-1), this gives 2^(WIDTH-1), which is correct.
    - bcd working register cleared, ovf_w=0, counter=WIDTH-1.
- SHIFT, once per cycle:
  - For each working digit, if digit>=5, add 3.
  - Shift the BCD chain left by one, shifting in the MSB of mag.
  - mag shifts left by one.
  - ovf_w |= the bit shifted out of the top digit's MSB.
  - counter decrements.
  - The last step occurs when counter==0; the edge executing it also moves the state to DONE.
- Output registration:
  - On entry to DONE, digits, neg and overflow load from the working registers.
  - They hold until the next entry to DONE or reset.
  - done=1 exactly while in DONE.
- Latency:
  - start sampled at edge k gives busy=1 after edges k..k+WIDTH-1.
  - done=1 and new outputs are visible after edge k+WIDTH.
  - Throughput is one conversion per WIDTH+1 cycles; back-to-back start held high sustains this.
- Overflow rule:
  - overflow=1 iff magnitude >= 10^DIGITS.
  - digits then holds magnitude mod 10^DIGITS, i.e. the low digits are still exact.
- Unsigned mode:
  - neg=0 always; a set numero[WIDTH-1] is treated as magnitude.
- Inputs numero and signed_en are ignored outside the accept cycle; changing them mid-conversion has no effect.

Decomposition:
- Package bcd_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - DIGIT_W=4, ADJ_THRESH=5, ADJ_ADD=3.
  - Function clog2 for counter width.
- Sub-module bcd_dabble_step (combinational, parameter DIGITS):
  - Inputs: bcd_in, bit_in.
  - Outputs: bcd_out, carry_out.
  - Performs one add-3-then-shift step.
  - Instantiated once in the SHIFT datapath; reusable by a future unrolled variant.

Test Plan (WIDTH=32, DIGITS=4 unless stated):
- start with numero=1234, signed_en=0:
  - done pulses exactly 32 cycles after the start edge.
  - digits=16'h1234, neg=0, overflow=0.
  - busy high for 32 cycles.
- numero=32'hFFFF_FFD6 (-42), signed_en=1: digits=16'h0042, neg=1, overflow=0.
- Same word 32'hFFFF_FFD6, signed_en=0: overflow=1, neg=0, digits=16'h7254 (4294967254 mod 10^4).
- numero=10000 unsigned: digits=16'h0000, overflow=1. numero=9999: digits=16'h9999, overflow=0.
- Handshake:
  - start pulsed again mid-SHIFT with a different value is ignored; the result is the first operand's.
  - start held high with 5 then 7 presented on successive accepts gives done pulses 33 cycles apart, digits 0x0005 then 0x0007.
- Reset and parameter corners:
  - Assert reset 10 cycles into a conversion: all outputs 0 immediately (asynchronous), no done afterwards, next start converts normally.
  - WIDTH=8, DIGITS=3, numero=8'h80 signed gives digits=12'h128, neg=1.
